// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types of the 5-stage MIPS datapath.
//   WORD_W / REG_W : datapath word width and register index width
//   word_t         : one datapath word
//   regbits_t      : one register index
//   ctrl_t         : 16-bit packed decode control word; every architectural
//                    write-enable (regwen, dwen) lives here, so zeroing the
//                    word is enough to turn an entry into a harmless bubble
//   REGDST_*       : encodings of ctrl_t.regdst (2'b11 selects register 0)
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic [1:0] regdst;
        logic       regwen;
        logic       dren;
        logic       dwen;
        logic       memtoreg;
        logic [1:0] branch;
        logic       jump;
        logic       halt;
        logic       lui;
    } ctrl_t;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

endpackage

// File: rtl/id_ex_if.sv
// ---------------------------------------------------------------------------
// id_ex_if
// Signal bundle between the decode stage, the hazard unit and the ID/EX
// pipeline register.
//   en, flush        : hazard-unit controls (load enable / bubble insert)
//   id_*             : decode-stage bundle presented for capture
//   ex_*             : registered bundle seen by the EX stage
//   stall_cnt,
//   bubble_cnt       : performance counters, present only when the macro
//                      ID_EX_PERF_EN is defined
// Handshake: no valid/ready pair here. The latch captures the id_* bundle on
// the rising clock edge whenever en=1 (and no flush/halt), otherwise holds;
// id_valid / ex_valid only mark whether an entry is a real instruction.
// Modports: latch (the pipeline register), tb (driver/monitor side).
// ---------------------------------------------------------------------------
interface id_ex_if import cpu_types_pkg::*; ;

    logic     en;
    logic     flush;
    logic     id_valid;
    word_t    id_pc4;
    word_t    id_rdat1;
    word_t    id_rdat2;
    word_t    id_extout;
    regbits_t id_rs;
    regbits_t id_rt;
    regbits_t id_rd;
    logic [4:0] id_shamt;
    ctrl_t    id_ctrl;

    logic     ex_valid;
    word_t    ex_pc4;
    word_t    ex_rdat1;
    word_t    ex_rdat2;
    word_t    ex_imm;
    regbits_t ex_rs;
    regbits_t ex_rt;
    regbits_t ex_wsel;
    logic [4:0] ex_shamt;
    ctrl_t    ex_ctrl;
    logic     ex_halt;

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    modport latch (
        input  en, flush, id_valid, id_pc4, id_rdat1, id_rdat2, id_extout,
               id_rs, id_rt, id_rd, id_shamt, id_ctrl,
`ifdef ID_EX_PERF_EN
        output stall_cnt, bubble_cnt,
`endif
        output ex_valid, ex_pc4, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt,
               ex_wsel, ex_shamt, ex_ctrl, ex_halt
    );

    modport tb (
        output en, flush, id_valid, id_pc4, id_rdat1, id_rdat2, id_extout,
               id_rs, id_rt, id_rd, id_shamt, id_ctrl,
`ifdef ID_EX_PERF_EN
        input  stall_cnt, bubble_cnt,
`endif
        input  ex_valid, ex_pc4, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt,
               ex_wsel, ex_shamt, ex_ctrl, ex_halt
    );

endinterface

// File: rtl/wsel_mux.sv
// ---------------------------------------------------------------------------
// wsel_mux
// Destination-register select from the RegDst control field. Purely
// combinational; shared with the single-cycle datapath.
//   i_regdst : ctrl_t.regdst
//   i_rt     : instruction rt field
//   i_rd     : instruction rd field
//   o_wsel   : rt, rd, 31 (JAL link register) or 0 for the unused code
// ---------------------------------------------------------------------------
module wsel_mux
    import cpu_types_pkg::*;
(
    input  logic [1:0] i_regdst,
    input  regbits_t   i_rt,
    input  regbits_t   i_rd,
    output regbits_t   o_wsel
);

    always_comb begin
        o_wsel = '0;
        case (i_regdst)
            REGDST_RT: o_wsel = i_rt;
            REGDST_RD: o_wsel = i_rd;
            REGDST_RA: o_wsel = '1;   // all ones = $31
            default:   o_wsel = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_latch.sv
// ---------------------------------------------------------------------------
// id_ex_latch
// ID/EX pipeline register of the 5-stage MIPS datapath.
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset, clears every output and the
//          halt lock
//   bus  : id_ex_if.latch -- en/flush controls, id_* capture bundle,
//          ex_* registered bundle (see id_ex_if for the list)
// Update priority on each rising edge: halt lock > flush > en > hold.
// A flush clears only valid, ctrl and wsel; the data fields are don't-care
// in a bubble because ctrl carries every write-enable.
// The halt lock is the only piece of internal state beyond the data
// registers; it is visible as ex_halt, which is set on the same edge.
// Optional macro ID_EX_PERF_EN adds saturating stall/bubble counters.
// ---------------------------------------------------------------------------
module id_ex_latch
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    nRST,
    id_ex_if.latch  bus
);

    logic       r_valid;
    word_t      r_pc4;
    word_t      r_rdat1;
    word_t      r_rdat2;
    word_t      r_imm;
    regbits_t   r_rs;
    regbits_t   r_rt;
    regbits_t   r_wsel;
    logic [4:0] r_shamt;
    ctrl_t      r_ctrl;
    logic       r_halt_lock;

    regbits_t   w_wsel;

    wsel_mux u_wsel_mux (
        .i_regdst (bus.id_ctrl.regdst),
        .i_rt     (bus.id_rt),
        .i_rd     (bus.id_rd),
        .o_wsel   (w_wsel)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid     <= 1'b0;
            r_pc4       <= '0;
            r_rdat1     <= '0;
            r_rdat2     <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_wsel      <= '0;
            r_shamt     <= '0;
            r_ctrl      <= '0;
            r_halt_lock <= 1'b0;
        end else if (r_halt_lock) begin
            // frozen until reset: en and flush are ignored
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_wsel  <= '0;
        end else if (bus.en) begin
            r_valid <= bus.id_valid;
            r_pc4   <= bus.id_pc4;
            r_rdat1 <= bus.id_rdat1;
            r_rdat2 <= bus.id_rdat2;
            r_imm   <= bus.id_extout;
            r_rs    <= bus.id_rs;
            r_rt    <= bus.id_rt;
            r_wsel  <= w_wsel;
            r_shamt <= bus.id_shamt;
            // an invalid decode slot enters EX as a bubble
            r_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
            if (bus.id_valid && bus.id_ctrl.halt) begin
                r_halt_lock <= 1'b1;
            end
        end
    end

    assign bus.ex_valid = r_valid;
    assign bus.ex_pc4   = r_pc4;
    assign bus.ex_rdat1 = r_rdat1;
    assign bus.ex_rdat2 = r_rdat2;
    assign bus.ex_imm   = r_imm;
    assign bus.ex_rs    = r_rs;
    assign bus.ex_rt    = r_rt;
    assign bus.ex_wsel  = r_wsel;
    assign bus.ex_shamt = r_shamt;
    assign bus.ex_ctrl  = r_ctrl;
    assign bus.ex_halt  = r_halt_lock;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (!r_halt_lock) begin
            if (bus.flush) begin
                if (r_bubble_cnt != 32'hFFFF_FFFF) begin
                    r_bubble_cnt <= r_bubble_cnt + 32'd1;
                end
            end else if (!bus.en) begin
                if (r_stall_cnt != 32'hFFFF_FFFF) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// ---------------------------------------------------------------------------
// tb_id_ex_latch
// Bench for id_ex_latch: a vector table of loads/holds/flushes, then
// hand-written stall, asynchronous reset and halt-freeze sequences. Expected
// bundles are pushed to exp_q when a vector is driven and popped after the
// capturing edge. With ID_EX_PERF_EN defined the counters are checked too.
// ---------------------------------------------------------------------------
module tb_id_ex_latch;
    import cpu_types_pkg::*;

    localparam int BW = 1 + 4*WORD_W + 4*REG_W + 16 + 1;

    typedef struct {
        logic       en;
        logic       flush;
        logic       valid;
        word_t      pc4;
        word_t      r1;
        word_t      r2;
        word_t      ext;
        regbits_t   rs;
        regbits_t   rt;
        regbits_t   rd;
        logic [4:0] sh;
        ctrl_t      ctrl;
        logic       exp_valid;
        regbits_t   exp_wsel;
        logic       exp_ctrl0;
        logic       exp_hold;
        logic       care;
        logic       exp_halt;
    } vec_t;

    logic CLK;
    logic nRST;

    id_ex_if bus ();

    id_ex_latch dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard state
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] mask_q[$];
    logic [BW-1:0] last_exp;
    logic [BW-1:0] last_mask;
    logic [BW-1:0] flush_mask;
    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[14];

    function automatic logic [BW-1:0] pack(logic v, word_t pc4, word_t r1,
        word_t r2, word_t imm, regbits_t rs, regbits_t rt, regbits_t wsel,
        logic [4:0] sh, ctrl_t c, logic h);
        return {v, pc4, r1, r2, imm, rs, rt, wsel, sh, c, h};
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return pack(bus.ex_valid, bus.ex_pc4, bus.ex_rdat1, bus.ex_rdat2,
                    bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_wsel,
                    bus.ex_shamt, bus.ex_ctrl, bus.ex_halt);
    endfunction

    function automatic regbits_t wsel_ref(logic [1:0] rd_sel, regbits_t rt, regbits_t rd);
        case (rd_sel)
            2'b00:   return rt;
            2'b01:   return rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic vec_t mk(logic en, logic flush, logic valid,
        logic [1:0] rd_sel, regbits_t rt, regbits_t rd, logic halt,
        regbits_t exp_wsel);
        vec_t v;
        v.en    = en;
        v.flush = flush;
        v.valid = valid;
        v.pc4   = $urandom;
        v.r1    = $urandom;
        v.r2    = $urandom;
        v.ext   = $urandom;
        v.rs    = 5'($urandom_range(0, 31));
        v.rt    = rt;
        v.rd    = rd;
        v.sh    = 5'($urandom_range(0, 31));
        v.ctrl         = '0;
        v.ctrl.aluop   = 4'($urandom_range(0, 15));
        v.ctrl.alusrc  = 1'($urandom_range(0, 1));
        v.ctrl.regdst  = rd_sel;
        v.ctrl.regwen  = 1'b1;
        v.ctrl.dwen    = 1'b1;
        v.ctrl.halt    = halt;
        v.exp_valid = valid;
        v.exp_wsel  = exp_wsel;
        v.exp_ctrl0 = !valid;
        v.exp_hold  = 1'b0;
        v.care      = 1'b1;
        v.exp_halt  = valid & halt;
        if (flush) begin
            v.exp_valid = 1'b0;
            v.exp_wsel  = '0;
            v.exp_ctrl0 = 1'b1;
            v.care      = 1'b0;
            v.exp_halt  = 1'b0;
        end else if (!en) begin
            v.exp_hold  = 1'b1;
        end
        return v;
    endfunction

    task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp,
                         logic [BW-1:0] mask);
        n_checks++;
        if ((act & mask) === (exp & mask)) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act & mask, exp & mask);
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // driver: apply one vector, push its expectation, compare after the edge
    task automatic step(vec_t v, string name);
        logic [BW-1:0] e;
        logic [BW-1:0] m;
        bus.en        = v.en;
        bus.flush     = v.flush;
        bus.id_valid  = v.valid;
        bus.id_pc4    = v.pc4;
        bus.id_rdat1  = v.r1;
        bus.id_rdat2  = v.r2;
        bus.id_extout = v.ext;
        bus.id_rs     = v.rs;
        bus.id_rt     = v.rt;
        bus.id_rd     = v.rd;
        bus.id_shamt  = v.sh;
        bus.id_ctrl   = v.ctrl;
        if (v.exp_hold) begin
            e = last_exp;
            m = last_mask;
        end else begin
            e = pack(v.exp_valid, v.pc4, v.r1, v.r2, v.ext, v.rs, v.rt,
                     v.exp_wsel, v.sh, v.exp_ctrl0 ? ctrl_t'('0) : v.ctrl,
                     v.exp_halt);
            m = v.care ? {BW{1'b1}} : flush_mask;
        end
        exp_q.push_back(e);
        mask_q.push_back(m);
        last_exp  = e;
        last_mask = m;
        @(posedge CLK);
        #1;
        check(name, dut_bundle(), exp_q.pop_front(), mask_q.pop_front());
    endtask

    task automatic reset_now(string name);
        nRST = 1'b0;
        #1;
        check(name, dut_bundle(), '0, {BW{1'b1}});
`ifdef ID_EX_PERF_EN
        check32({name, "_stall_cnt"}, bus.stall_cnt, 32'd0);
        check32({name, "_bubble_cnt"}, bus.bubble_cnt, 32'd0);
`endif
        last_exp  = '0;
        last_mask = {BW{1'b1}};
        #2;
        nRST = 1'b1;
    endtask

    initial begin
        vec_t v;
`ifdef ID_EX_PERF_EN
        logic [31:0] base_stall;
`endif
        flush_mask = pack(1'b1, '0, '0, '0, '0, '0, '0, '1, '0, '1, 1'b1);

        // vector table
        vecs[0] = mk(1, 0, 1, 2'b00, 5'd5, 5'd12, 0, 5'd5);
        vecs[0].ext = 32'hFFFF8000;
        vecs[1] = mk(1, 0, 1, 2'b01, 5'd4, 5'd9, 0, 5'd9);
        vecs[2] = mk(1, 0, 1, 2'b10, 5'd2, 5'd7, 0, 5'd31);
        vecs[3] = mk(1, 0, 1, 2'b11, 5'd6, 5'd8, 0, 5'd0);
        vecs[4] = mk(0, 0, 1, 2'b01, 5'd1, 5'd2, 0, 5'd2);
        vecs[5] = mk(1, 0, 0, 2'b00, 5'd3, 5'd10, 0, 5'd3);
        vecs[6] = mk(1, 1, 1, 2'b01, 5'd3, 5'd10, 0, 5'd10);
        vecs[7] = mk(0, 1, 1, 2'b00, 5'd11, 5'd13, 0, 5'd11);
        for (int i = 8; i < 14; i++) begin
            regbits_t rt;
            regbits_t rd;
            logic [1:0] sel;
            rt  = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            sel = 2'($urandom_range(0, 3));
            vecs[i] = mk(1, 0, 1, sel, rt, rd, 0, wsel_ref(sel, rt, rd));
        end

        // reset
        bus.en = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_pc4 = '0; bus.id_rdat1 = '0; bus.id_rdat2 = '0;
        bus.id_extout = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_shamt = '0; bus.id_ctrl = '0;
        nRST = 1'b0;
        #1;
        check("reset_outputs", dut_bundle(), '0, {BW{1'b1}});
        last_exp  = '0;
        last_mask = {BW{1'b1}};
        repeat (2) @(posedge CLK);
        #2;
        nRST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // stall: pc4=4 held for three cycles while the input shows 8
        v = mk(1, 0, 1, 2'b00, 5'd5, 5'd6, 0, 5'd5);
        v.pc4 = 32'h4;
        step(v, "stall_load");
`ifdef ID_EX_PERF_EN
        base_stall = bus.stall_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            v = mk(0, 0, 1, 2'b01, 5'd5, 5'd6, 0, 5'd6);
            v.pc4 = 32'h8;
            step(v, $sformatf("stall_hold%0d", i));
        end
`ifdef ID_EX_PERF_EN
        check32("stall_cnt_delta", bus.stall_cnt - base_stall, 32'd3);
`endif

        // asynchronous reset while a valid entry is held
        #2;
        reset_now("async_reset");

        // flush on the same edge as a halt load: no halt latched
        v = mk(1, 1, 1, 2'b01, 5'd1, 5'd4, 1, 5'd4);
        step(v, "flush_vs_halt");
        v = mk(0, 0, 1, 2'b00, 5'd2, 5'd3, 0, 5'd2);
        step(v, "after_flush_vs_halt");

        // halt load, then en/flush ignored
        v = mk(1, 0, 1, 2'b01, 5'd1, 5'd4, 1, 5'd4);
        step(v, "halt_load");
        v = mk(1, 1, 1, 2'b00, 5'd9, 5'd9, 0, 5'd9);
        v.exp_hold = 1'b1;
        step(v, "halt_freeze_flush");
        v = mk(1, 0, 1, 2'b01, 5'd9, 5'd14, 0, 5'd14);
        v.exp_hold = 1'b1;
        step(v, "halt_freeze_load");
        v = mk(0, 1, 1, 2'b10, 5'd9, 5'd14, 0, 5'd31);
        v.exp_hold = 1'b1;
        step(v, "halt_freeze_flush_noen");
`ifdef ID_EX_PERF_EN
        check32("halt_stall_cnt", bus.stall_cnt, 32'd1);
        check32("halt_bubble_cnt", bus.bubble_cnt, 32'd1);
`endif

        // only reset releases the halt lock
        #2;
        reset_now("halt_reset");
        v = mk(1, 0, 1, 2'b01, 5'd3, 5'd17, 0, 5'd17);
        step(v, "post_halt_load");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- ID/EX pipeline register of the 5-stage MIPS datapath.
- Captures the decode-stage bundle: PC+4, register-file read data, extender output, rs/rt/rd fields, shamt and control word.
- Presents that bundle to the EX stage (ALU operand mux, branch target adder).
- Implements stall (hold), flush (bubble insert) and halt freeze.

Parameters:
- WORD_W, 32, datapath word width.
- REG_W, 5, register index width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  load enable: ihit and not hazard-stall, driven by the hazard unit.
- flush  in  1  replace the captured entry with a bubble: branch/jump taken or load-use.
- id_valid  in  1  decode stage holds a real instruction.
- id_pc4  in  WORD_W  PC+4 of the decode instruction.
- id_rdat1  in  WORD_W  rs read data.
- id_rdat2  in  WORD_W  rt read data.
- id_extout  in  WORD_W  extender output (sign-extended, zero-extended or LUI-shifted).
- id_rs, id_rt, id_rd  in  REG_W each  instruction register fields.
- id_shamt  in  5  shift amount.
- id_ctrl  in  ctrl_t (16)  packed control word.
- ex_valid  out  1  EX entry is a real instruction.
- ex_pc4, ex_rdat1, ex_rdat2, ex_imm  out  WORD_W  latched copies.
- ex_rs, ex_rt  out  REG_W  latched copies, used by the forwarding unit.
- ex_wsel  out  REG_W  destination register selected from RegDst.
- ex_shamt  out  5  latched shamt.
- ex_ctrl  out  ctrl_t  latched control word, forced to all-zero when the entry is a bubble.
- ex_halt  out  1  sticky halt indication.

Behaviour:
- Reset (nRST low, asynchronous): all outputs 0; halt_lock cleared.
- Update on the CLK rising edge. Priority: halt_lock > flush > en > hold.
- halt_lock set: register contents freeze; en and flush are ignored until reset.
- flush=1: ex_valid=0, ex_ctrl=0, ex_wsel=0. Data fields may take any value; the bench must not check them.
- Bubble guarantee: a bubble never writes the register file or memory. This holds because every write-enable lives in ctrl_t.
- flush and en both high: flush wins.
- en=1, flush=0: load every field. Then:
  - ex_valid = id_valid.
  - If id_valid=0, ex_ctrl is loaded as 0.
- en=0, flush=0: hold all outputs (stall), including ex_halt.
- ex_wsel is computed at load time from ctrl.regdst:
  - 00 → id_rt
  - 01 → id_rd
  - 10 → 5'd31 (JAL)
  - 11 → 0
- Halt: when a valid entry with ctrl.halt=1 is loaded, ex_halt=1 and halt_lock sets on the same edge. ex_halt stays 1 until reset.
- Flush on the same cycle as a halt load: flush wins and no halt is latched.
- Latency: exactly one cycle from ID inputs to EX outputs. No combinational path from inputs to outputs.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds outputs stall_cnt (32) and bubble_cnt (32).
  - stall_cnt increments each cycle with en=0, flush=0 and halt_lock=0.
  - bubble_cnt increments on each flush edge.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on nRST.
  - Both counters freeze while halt_lock is set.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to cpu_types_pkg:
  - ctrl_t packed struct, in this order: aluop[3:0], alusrc, regdst[1:0], regwen, dren, dwen, memtoreg, branch[1:0], jump, halt, lui.
  - REGDST_RT/RD/RA constants.
  - Reuse the existing word_t and regbits_t.
- Sub-module wsel_mux: the regdst→wsel selection, purely combinational and reused by the single-cycle datapath.
- Interface id_ex_if with modports "latch" and "tb", matching the other stage interfaces.

Test Plan:
- Reset: assert nRST=0 mid-run with ex_valid=1 → all outputs 0 immediately, without waiting for a clock edge.
- Load: en=1, id_extout=32'hFFFF8000, id_rt=5, regdst=00, regwen=1 → next edge ex_imm=32'hFFFF8000, ex_wsel=5, ex_valid=1.
- Stall: load PC4=32'h4, then hold en=0 for 3 cycles while id_pc4=32'h8 → ex_pc4 stays 32'h4. With ID_EX_PERF_EN, stall_cnt=3.
- Flush priority: en=1, flush=1, id_ctrl.regwen=1, dwen=1 → ex_valid=0, ex_ctrl=0, ex_wsel=0.
- JAL: regdst=10, id_rd=7 → ex_wsel=31.
- Halt: load a valid entry with halt=1, then apply en=1 with new data and flush=1 → ex_halt=1, outputs frozen, and flush ignored until nRST.
